// File: rtl/debounce_pkg.sv
// Shared types and 50 MHz default timings for the multi-channel debouncer.
// The repeat-state enum is only referenced when DEBOUNCE_REPEAT_EN is defined.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } rpt_state_e;

   // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
   localparam int unsigned REPEAT_DELAY_DEFAULT    = 25_000_000;
   localparam int unsigned REPEAT_PERIOD_DEFAULT   = 5_000_000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchronizer, integration counter, stable level and press/release pulses.
// Auto-repeat FSM is built only when DEBOUNCE_REPEAT_EN is defined.
//
// state     | meaning
// IDLE      | button released or press not yet accepted
// HOLD_WAIT | press accepted, counting REPEAT_DELAY before the first repeat
// REPEAT    | emitting a press pulse every REPEAT_PERIOD cycles while held
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter bit          ACTIVE_LOW_IN   = 1'b1
`ifdef DEBOUNCE_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   output logic db_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic event_next
);

   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   in_int, sync_lvl, accept, rise, fall, rpt_fire;

   assign in_int   = ACTIVE_LOW_IN ? ~button_in : button_in;
   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign accept   = (sync_lvl != stable_q) && (cnt_q == CNT_LAST);
   assign rise     = accept & sync_lvl;
   assign fall     = accept & ~sync_lvl;

   // A single matching sample clears the count, so only an unbroken run is accepted
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], in_int};
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_lvl != stable_q) begin
         if (accept) begin
            stable_d = sync_lvl;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int unsigned      RPT_W       = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   rpt_state_e       rpt_state_q, rpt_state_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

   always_comb begin
      rpt_state_d = rpt_state_q;
      rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
      rpt_fire    = 1'b0;
      unique case (rpt_state_q)
         IDLE: begin
            rpt_cnt_d = '0;
            if (rise) begin
               rpt_state_d = HOLD_WAIT;
            end
         end
         HOLD_WAIT: begin
            if (!stable_q) begin
               rpt_state_d = IDLE;
               rpt_cnt_d   = '0;
            end else if (rpt_cnt_q == DELAY_LAST) begin
               rpt_state_d = REPEAT;
               rpt_cnt_d   = '0;
               rpt_fire    = 1'b1;
            end
         end
         REPEAT: begin
            if (!stable_q) begin
               rpt_state_d = IDLE;
               rpt_cnt_d   = '0;
            end else if (rpt_cnt_q == PERIOD_LAST) begin
               rpt_cnt_d = '0;
               rpt_fire  = 1'b1;
            end
         end
         default: begin
            rpt_state_d = IDLE;
            rpt_cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_state_q <= IDLE;
         rpt_cnt_q   <= '0;
      end else begin
         rpt_state_q <= rpt_state_d;
         rpt_cnt_q   <= rpt_cnt_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign press_d    = rise | rpt_fire;
   assign release_d  = fall;
   assign event_next = press_d | release_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         stable_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         stable_q  <= stable_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign db_out        = stable_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel pushbutton/switch debouncer with registered level, press/release pulses and any_event.
// Define DEBOUNCE_REPEAT_EN to add per-channel auto-repeat on held buttons.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter bit          ACTIVE_LOW_IN   = 1'b1,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button_in,
   output logic [CHANNELS-1:0] db_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic                any_event
);

   logic [CHANNELS-1:0] event_next;
   logic                any_event_q, any_event_d;

`ifndef DEBOUNCE_REPEAT_EN
   // Repeat timings are accepted but have no effect without the repeat FSM
   localparam int unsigned REPEAT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
`ifdef DEBOUNCE_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .button_in     (button_in[g]),
         .db_out        (db_out[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g]),
         .event_next    (event_next[g])
      );
   end

   // Registered from the channels' next-pulse terms so it lines up with the pulses
   always_comb begin
      any_event_d = |event_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         any_event_q <= 1'b0;
      end else begin
         any_event_q <= any_event_d;
      end
   end

   assign any_event = any_event_q;

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised N-channel debouncer for pushbuttons and switches feeding the processor I/O block.
- Each channel has a configurable synchronizer, an integration counter, a registered stable level, and one-cycle press/release pulses.
- Replaces per-button single-channel instances.
- Adds selectable input polarity and an optional auto-repeat for held buttons.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a new level (>=1; 20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer flops per channel (>=2).
- ACTIVE_LOW_IN, 1: 1 means raw input is inverted before synchronization, so a pressed button reads as 1 internally.
- REPEAT_DELAY, 25_000_000: cycles held before the first auto-repeat pulse (feature only).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeat pulses (feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- button_in  in  CHANNELS  raw asynchronous inputs.
- db_out  out  CHANNELS  debounced level, 1 = pressed/active.
- press_pulse  out  CHANNELS  one-cycle pulse on accepted 0->1.
- release_pulse  out  CHANNELS  one-cycle pulse on accepted 1->0.
- any_event  out  1  OR of all press_pulse and release_pulse bits, registered alongside them.

Behaviour:
- Reset:
  - All synchronizer flops load the inactive level (internal 0).
  - All counters load 0.
  - db_out, press_pulse, release_pulse and any_event load 0.
  - Reset asserted mid-count discards all progress; after release, every channel restarts from inactive.
- Input polarity: the inversion for ACTIVE_LOW_IN is applied combinationally before the first sync flop.
- Per channel, sync = last synchronizer stage; stable = db_out register.
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0, and the matching pulse asserts in the same cycle db_out changes.
- Acceptance therefore requires exactly DEBOUNCE_CYCLES consecutive differing samples. Any single matching sample restarts the count (glitch rejection).
- Latency from a clean input step to db_out change: SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- Pulses are exactly one cycle wide and never assert while db_out is unchanged.
- Channels are fully independent. Simultaneous acceptances on several channels each pulse in the same cycle, with any_event = 1 for that single cycle.
- Counter width is the localparam $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Outputs are all registered; there is no combinational path from button_in.

Optional Feature:
- Macro DEBOUNCE_REPEAT_EN.
- When defined, each channel gets a repeat FSM with states IDLE, HOLD_WAIT, REPEAT:
  - IDLE -> HOLD_WAIT on press_pulse.
  - HOLD_WAIT -> REPEAT after REPEAT_DELAY cycles with db_out=1, emitting an extra one-cycle press_pulse.
  - In REPEAT, emit press_pulse every REPEAT_PERIOD cycles.
  - Any state -> IDLE when db_out=0 (release_pulse is still generated normally).
  - The repeat counter uses width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) and resets to 0 on every state change.
- When not defined, no FSM or repeat counter is synthesized, REPEAT_* parameters are ignored, and press_pulse fires once per accepted press.

Decomposition:
- Package debounce_pkg:
  - repeat-state enum (IDLE, HOLD_WAIT, REPEAT);
  - default constants for 50 MHz timings (20 ms debounce, 500 ms delay, 100 ms period).
- Sub-module debounce_channel: one channel's synchronizer, counter, stable register, pulse logic and optional repeat FSM.
- debounce_multi instantiates CHANNELS copies via generate and forms any_event.

Test Plan:
Bench: CHANNELS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW_IN=0.
1. Clean step: ch0 0->1 held 10 cycles -> db_out[0]=1 on edge 6 after the step; press_pulse[0] and any_event high for exactly that cycle.
2. Bounce: ch1 toggled 1,0,1,0 at 1-cycle spacing then held 1 -> no pulse during bounce; db_out[1] rises 6 edges after the final 0->1.
3. Glitch: ch2 high for 3 cycles then low -> db_out[2] stays 0; no pulses.
4. Simultaneous: ch0 and ch3 released in the same cycle after both pressed -> release_pulse=4'b1001 in one cycle; any_event single-cycle high.
5. Reset mid-count: ch1 high for 2 cycles, then reset low for 1 cycle -> all outputs 0 immediately; db_out[1] rises only 6 edges after reset deasserts.
6. DEBOUNCE_REPEAT_EN with REPEAT_DELAY=8, REPEAT_PERIOD=3, ch0 held 20 cycles past acceptance -> press_pulse[0] at +0, +8, +11, +14, +17; one release_pulse on let-go.
